// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C slave byte engine and the downstream frame bridge.
package i2c_pkg;

    localparam int CNT_W = 4;

    localparam logic [CNT_W-1:0] BITS_PER_BYTE = CNT_W'(8);
    localparam logic [CNT_W-1:0] LAST_BIT_IDX  = CNT_W'(7);

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    localparam int BRIDGE_DATA_W     = 8;
    localparam int BRIDGE_FIFO_DEPTH = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_BYTE,
        ST_WR_ACK,
        ST_RD_BYTE,
        ST_RD_ACK,
        ST_WAIT_STOP
    } i2c_state_e;

    function automatic logic addr_hit(input logic [7:0] addr_byte, input logic [6:0] dev_addr);
        return addr_byte[7:1] == dev_addr;
    endfunction

endpackage

// File: rtl/i2c_sync_edge.sv
// One bus line: synchroniser, optional 3-sample majority filter (I2C_GLITCH_FILTER_EN),
// and registered rise/fall pulses aligned with the delayed level output.
module i2c_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line_i,
    output logic line_s,
    output logic rise,
    output logic fall
);

    // Idle bus is high, so reset the chain high to avoid a spurious edge after reset.
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   line_clean;
    logic                   prev_q;
    logic                   rise_q;
    logic                   fall_q;
    logic                   rise_d;
    logic                   fall_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], line_i};
        end
    end

`ifdef I2C_GLITCH_FILTER_EN
    logic [1:0] hist_q;
    logic       filt_q;
    logic       filt_d;

    always_comb begin
        filt_d = (sync_q[SYNC_STAGES-1] & hist_q[0]) |
                 (sync_q[SYNC_STAGES-1] & hist_q[1]) |
                 (hist_q[0] & hist_q[1]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= 2'b11;
            filt_q <= 1'b1;
        end else begin
            hist_q <= {hist_q[0], sync_q[SYNC_STAGES-1]};
            filt_q <= filt_d;
        end
    end

    assign line_clean = filt_q;
`else
    assign line_clean = sync_q[SYNC_STAGES-1];
`endif

    always_comb begin
        rise_d = line_clean & ~prev_q;
        fall_d = ~line_clean & prev_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b1;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            prev_q <= line_clean;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign line_s = prev_q;
    assign rise   = rise_q;
    assign fall   = fall_q;

endmodule

// File: rtl/i2c_slave_byte_engine.sv
// Bit-level I2C slave: START/Sr/STOP detection, address match, byte shifting and ACK.
// Build option I2C_GLITCH_FILTER_EN adds a majority glitch filter on SCL/SDA.
module i2c_slave_byte_engine
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_valid,
    output logic       sr_start,
    output logic       inframe,
    output logic       rw_bit,
    output logic       addr_match,
    output logic       edge_detect
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl (
        .clk    (clk),
        .rst_n  (rst_n),
        .line_i (scl_i),
        .line_s (scl_lvl),
        .rise   (scl_rise),
        .fall   (scl_fall)
    );

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda (
        .clk    (clk),
        .rst_n  (rst_n),
        .line_i (sda_i),
        .line_s (sda_lvl),
        .rise   (sda_rise),
        .fall   (sda_fall)
    );

    logic start_det, stop_det;
    assign start_det = sda_fall & scl_lvl;
    assign stop_det  = sda_rise & scl_lvl;

    i2c_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       tx_shift_q, tx_shift_d;
    logic             mack_q, mack_d;
    logic             sda_oe_q, sda_oe_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             tx_valid_q, tx_valid_d;
    logic             sr_start_q, sr_start_d;
    logic             inframe_q, inframe_d;
    logic             rw_q, rw_d;
    logic             addr_match_q, addr_match_d;
    logic [7:0]       shift_in;

    assign shift_in = {shift_q[6:0], sda_lvl};

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        tx_shift_d   = tx_shift_q;
        mack_d       = mack_q;
        sda_oe_d     = sda_oe_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        tx_valid_d   = 1'b0;
        sr_start_d   = 1'b0;
        inframe_d    = inframe_q;
        rw_d         = rw_q;
        addr_match_d = addr_match_q;

        // Bus conditions override any bit activity seen in the same cycle.
        if (stop_det) begin
            state_d      = ST_IDLE;
            inframe_d    = 1'b0;
            addr_match_d = 1'b0;
            sda_oe_d     = 1'b0;
            cnt_d        = '0;
        end else if (start_det) begin
            sr_start_d   = (state_q != ST_IDLE);
            state_d      = ST_ADDR;
            inframe_d    = 1'b1;
            addr_match_d = 1'b0;
            sda_oe_d     = 1'b0;
            cnt_d        = '0;
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_ADDR: begin
                    if (scl_rise && cnt_q < BITS_PER_BYTE) begin
                        shift_d = shift_in;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end else if (scl_fall && cnt_q == BITS_PER_BYTE) begin
                        cnt_d = '0;
                        if (addr_hit(shift_q, SLAVE_ADDR)) begin
                            sda_oe_d     = ~ACK;
                            rw_d         = shift_q[0];
                            addr_match_d = 1'b1;
                            state_d      = ST_ADDR_ACK;
                        end else begin
                            sda_oe_d     = 1'b0;
                            addr_match_d = 1'b0;
                            state_d      = ST_WAIT_STOP;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        cnt_d = '0;
                        if (rw_q) begin
                            tx_shift_d = tx_data;
                            tx_valid_d = 1'b1;
                            sda_oe_d   = ~tx_data[7];
                            state_d    = ST_RD_BYTE;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = ST_WR_BYTE;
                        end
                    end
                end
                ST_WR_BYTE: begin
                    if (scl_rise && cnt_q < BITS_PER_BYTE) begin
                        shift_d = shift_in;
                        cnt_d   = cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_BIT_IDX) begin
                            rx_data_d  = shift_in;
                            rx_valid_d = 1'b1;
                        end
                    end else if (scl_fall && cnt_q == BITS_PER_BYTE) begin
                        sda_oe_d = ~ACK;
                        cnt_d    = '0;
                        state_d  = ST_WR_ACK;
                    end
                end
                ST_WR_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        state_d  = ST_WR_BYTE;
                    end
                end
                ST_RD_BYTE: begin
                    if (scl_rise && cnt_q < BITS_PER_BYTE) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else if (scl_fall && cnt_q != '0) begin
                        if (cnt_q == BITS_PER_BYTE) begin
                            sda_oe_d = 1'b0;
                            cnt_d    = '0;
                            state_d  = ST_RD_ACK;
                        end else begin
                            tx_shift_d = {tx_shift_q[6:0], 1'b0};
                            sda_oe_d   = ~tx_shift_q[6];
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise) begin
                        mack_d = sda_lvl;
                    end else if (scl_fall) begin
                        if (mack_q == ACK) begin
                            tx_shift_d = tx_data;
                            tx_valid_d = 1'b1;
                            sda_oe_d   = ~tx_data[7];
                            cnt_d      = '0;
                            state_d    = ST_RD_BYTE;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = ST_WAIT_STOP;
                        end
                    end
                end
                ST_WAIT_STOP: sda_oe_d = 1'b0;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            shift_q      <= '0;
            tx_shift_q   <= '0;
            mack_q       <= NACK;
            sda_oe_q     <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            tx_valid_q   <= 1'b0;
            sr_start_q   <= 1'b0;
            inframe_q    <= 1'b0;
            rw_q         <= 1'b0;
            addr_match_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            tx_shift_q   <= tx_shift_d;
            mack_q       <= mack_d;
            sda_oe_q     <= sda_oe_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            tx_valid_q   <= tx_valid_d;
            sr_start_q   <= sr_start_d;
            inframe_q    <= inframe_d;
            rw_q         <= rw_d;
            addr_match_q <= addr_match_d;
        end
    end

    assign sda_oe      = sda_oe_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_valid    = tx_valid_q;
    assign sr_start    = sr_start_q;
    assign inframe     = inframe_q;
    assign rw_bit      = rw_q;
    assign addr_match  = addr_match_q;
    assign edge_detect = scl_fall;

endmodule

// File: doc/i2c_slave_byte_engine.md
Name: i2c_slave_byte_engine

Overview:
- Bit-level I2C slave front end; sits directly upstream of the frame bridge.
- Synchronises SCL/SDA, detects START / repeated START / STOP, and shifts bytes in and out.
- Matches the 7-bit device address, drives ACK/NACK and read data onto SDA (open-drain), and gives the bridge byte strobes and frame status.

Parameters:
- SLAVE_ADDR, 7'h50, 7-bit device address answered with ACK.
- SYNC_STAGES, 2, flip-flop synchroniser depth on scl_i and sda_i (minimum 2).

Ports:
- clk  in  1  system clock; must be ≥ 8× SCL frequency.
- rst_n  in  1  asynchronous, active-low reset.
- scl_i  in  1  raw SCL pad input.
- sda_i  in  1  raw SDA pad input.
- sda_oe  out  1  1 = pull SDA low; 0 = release.
- rx_data  out  8  last received data byte; held until the next rx_valid.
- rx_valid  out  1  one-cycle pulse: new rx_data (write-phase data bytes only; never the address byte).
- tx_data  in  8  read byte supplied by the bridge.
- tx_valid  out  1  one-cycle pulse: tx_data loaded into the transmit shifter this cycle.
- sr_start  out  1  one-cycle pulse on a repeated START (START while inframe).
- inframe  out  1  high from START detect to STOP detect.
- rw_bit  out  1  R/W bit of the last address byte (1 = read).
- addr_match  out  1  high from the ACK of a matching address until STOP or Sr.
- edge_detect  out  1  one-cycle pulse on every synchronised SCL falling edge.

Behaviour:
- Reset: every output is 0, state = IDLE, shifters cleared. Reset mid-transfer releases SDA immediately (asynchronous).
- Edges and conditions:
  - Synchronised scl_s/sda_s are compared with their previous-cycle values.
  - START = sda_s falls while scl_s high. STOP = sda_s rises while scl_s high.
  - Bits are sampled on scl_s rising. sda_oe changes only on scl_s falling.
- Latency: SYNC_STAGES+1 clk from a pad edge to the internal event.
- States: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP.
- IDLE → ADDR on START: inframe=1, bit counter=0.
- ADDR: shift 8 bits MSB first. After bit 8, at the next SCL fall:
  - On match: sda_oe=1 (ACK), rw_bit latched, addr_match=1 → ADDR_ACK.
  - On mismatch: sda_oe=0, addr_match=0 → WAIT_STOP.
- ADDR_ACK: at the SCL fall that ends the ACK:
  - rw=0: release SDA → WR_BYTE.
  - rw=1: load tx_data, pulse tx_valid, drive the MSB → RD_BYTE.
- WR_BYTE: after the 8th rising edge, update rx_data and pulse rx_valid (same cycle). At the next fall assert ACK → WR_ACK. At the fall ending the ACK release SDA → WR_BYTE.
- RD_BYTE: drive bits MSB first (sda_oe = ~bit). After the 8th bit, at the next fall release SDA → RD_ACK.
- RD_ACK: sample master ACK on the SCL rise.
  - ACK (0): at the fall, reload tx_data, pulse tx_valid → RD_BYTE.
  - NACK (1): → WAIT_STOP, no tx_valid.
- WAIT_STOP: SDA released; wait for STOP or Sr.
- STOP in any state (including mid-byte):
  - → IDLE; inframe=0, addr_match=0, sda_oe=0.
  - No rx_valid for a partial byte.
- Sr in any non-IDLE state:
  - Pulse sr_start; clear addr_match and the bit counter → ADDR.
  - inframe stays 1.
- Simultaneous events: STOP/START detection takes priority over bit sampling in the same cycle.
- START and STOP in the same cycle cannot occur: SDA transitions once per cycle.

Optional Feature:
- I2C_GLITCH_FILTER_EN defined: 3-sample majority filter on scl_s and sda_s after the synchroniser.
  - Suppresses pulses of 1 clk or shorter.
  - Adds 2 clk latency to all events.
- Undefined: no filter; raw synchroniser outputs are used.

Decomposition:
- Package i2c_pkg holds:
  - state encodings;
  - bit-counter width (4);
  - ACK=0 / NACK=1 constants;
  - shared frame-bridge localparams.
- Sub-module i2c_sync_edge: synchroniser, optional glitch filter, and registered rise/fall pulses for one line. Instantiated twice, for SCL and SDA.

Test Plan:
- Write to 0x50: START, 0xA0, 0x12, 0x34, 0xDE, 0xAD, STOP → ACK on all five bytes; rx_valid pulses 4× with 0x12, 0x34, 0xDE, 0xAD; addr_match=1 from the first ACK; inframe falls at STOP.
- Address mismatch: START, 0xA2, STOP → NACK (sda_oe=0 on the 9th clock); addr_match=0; no rx_valid; return to IDLE.
- Combined read: START, 0xA0, 0x00, 0x04, Sr, 0xA1, four bytes read with tx_data = 0x11/0x22/0x33/0x44, master NACK on byte 4 → sr_start pulses once; rw_bit=1; SDA shows 0x11, 0x22, 0x33, 0x44; exactly 4 tx_valid pulses.
- STOP mid-byte: START, 0xA0, 5 bits of 0xFF, STOP → no rx_valid; state IDLE; sda_oe=0.
- Reset mid-read: assert rst_n=0 while sda_oe=1 → sda_oe=0 in the same cycle; all outputs 0.
- With I2C_GLITCH_FILTER_EN: 1-clk SDA low glitch while SCL high → no START detected; inframe stays 0.
